// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM with memory-wait watchdog and sticky error flags.
// Define MC_PERF_CNT_EN to build the retired-instruction and cycle counters.
module mc_control_fsm #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             illegal,
    output logic             bus_err,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_LW    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_SLTI = 6'd2;
    localparam logic [5:0] OP_LW   = 6'd3;
    localparam logic [5:0] OP_SW   = 6'd4;
    localparam logic [5:0] OP_BEQ  = 6'd5;
    localparam logic [5:0] OP_J    = 6'd6;

    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b011;

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait;
    logic [7:0] w_wait_inc;
    logic       w_wait_hit;
    logic       w_wait_state;
    logic       w_stall;
    logic       w_set_ill;
    logic       w_set_bus;
    logic       r_illegal;
    logic       r_bus_err;

    // The branch decision is made in the datapath (pc_write_cond & zero).
    logic w_unused;
    assign w_unused = zero;

    assign w_wait_inc   = r_wait + 8'd1;
    assign w_wait_hit   = (w_wait_inc == WAIT_MAX);
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                          (r_state == S_MEM_WR);
    assign w_stall      = w_wait_state && !mem_ready && !w_wait_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_stall ? w_wait_inc : 8'd0;
            if (w_set_ill) r_illegal <= 1'b1;
            if (w_set_bus) r_bus_err <= 1'b1;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_set_ill = 1'b0;
        w_set_bus = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_wait_hit) begin
                    w_next    = S_HALT;
                    w_set_bus = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:             w_next = S_EXEC_R;
                    OP_ADDI, OP_SLTI: w_next = S_EXEC_I;
                    OP_LW, OP_SW:     w_next = S_MEM_ADDR;
                    OP_BEQ:           w_next = S_BRANCH;
                    OP_J:             w_next = S_JUMP;
                    default: begin
                        w_next    = S_HALT;
                        w_set_ill = 1'b1;
                    end
                endcase
            end
            S_EXEC_R:   w_next = S_WB_R;
            S_EXEC_I:   w_next = S_WB_I;
            S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) begin
                    w_next = S_WB_LW;
                end else if (w_wait_hit) begin
                    w_next    = S_HALT;
                    w_set_bus = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_wait_hit) begin
                    w_next    = S_HALT;
                    w_set_bus = 1'b1;
                end
            end
            S_WB_R, S_WB_I, S_WB_LW, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Controls are forced low for as long as rst is high, so an aborted access never writes.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_FUNCT;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = ALU_ADD;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = ALU_ADD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_WB_I: reg_write = 1'b1;
                S_WB_LW: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign illegal = r_illegal;
    assign bus_err = r_bus_err;
    assign state_o = r_state;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] r_instr_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic             w_retire;

    assign w_retire = (r_state == S_WB_R) || (r_state == S_WB_I) || (r_state == S_WB_LW) ||
                      (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                      ((r_state == S_MEM_WR) && mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_cnt <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_retire)          r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    assign instr_cnt = r_instr_cnt;
    assign cycle_cnt = r_cycle_cnt;
`else
    assign instr_cnt = '0;
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, watchdog/reset sequences, random instruction stream.
module tb_mc_control_fsm;

    localparam int WMAX  = 4;
    localparam int CNT_W = 32;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, ER = 4'd2, EI = 4'd3, MA = 4'd4, MR = 4'd5,
                           MW = 4'd6, WR = 4'd7, WI = 4'd8, WL = 4'd9, BR = 4'd10, JP = 4'd11,
                           HL = 4'd12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       opcode = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, reg_write, alu_src_a, illegal, bus_err;
    logic [1:0]       pc_src, alu_src_b;
    logic [2:0]       alu_op;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] instr_cnt, cycle_cnt;
    logic [16:0]      act_ctl;

    mc_control_fsm #(.MEM_WAIT_MAX(WMAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal), .bus_err(bus_err),
        .state_o(state_o), .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    assign act_ctl = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
                      reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic        ill;
        logic        bus;
    } vec_t;

    vec_t             tv[$];
    int               n_vec = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] m_cyc = '0;
    logic [CNT_W-1:0] m_ins = '0;
    logic [16:0]      K_Z, K_FS, K_FR, K_DE, K_ER, K_EA, K_ES, K_MR, K_MW, K_WR, K_WI, K_WL,
                      K_BR, K_JP;

    function automatic logic [16:0] cw(input logic pcw, input logic pcwc, input logic [1:0] pcs,
                                       input logic iod, input logic mr, input logic mw,
                                       input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic sa, input logic [1:0] sb,
                                       input logic [2:0] op);
        return {pcw, pcwc, pcs, iod, mr, mw, irw, rd, m2r, rw, sa, sb, op};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle's inputs, compare mid-cycle, then advance the counter model.
    task automatic apply(input string tag, input vec_t v);
        logic [CNT_W-1:0] e_ic, e_cc;
        rst = v.r; opcode = v.op; zero = v.z; mem_ready = v.mr;
        @(negedge clk);
`ifdef MC_PERF_CNT_EN
        e_ic = m_ins; e_cc = m_cyc;
`else
        e_ic = '0; e_cc = '0;
`endif
        n_vec++;
        if (state_o !== v.st || act_ctl !== v.ctl || illegal !== v.ill || bus_err !== v.bus ||
            instr_cnt !== e_ic || cycle_cnt !== e_cc) begin
            n_bad++;
            $display("FAIL %s: got st=%0d ctl=%h ill=%b bus=%b ic=%0d cc=%0d, want st=%0d ctl=%h ill=%b bus=%b ic=%0d cc=%0d",
                     tag, state_o, act_ctl, illegal, bus_err, instr_cnt, cycle_cnt,
                     v.st, v.ctl, v.ill, v.bus, e_ic, e_cc);
        end
        if (v.r) begin
            m_cyc = '0; m_ins = '0;
        end else begin
            if (v.st != HL) m_cyc++;
            if ((v.st inside {WR, WI, WL, BR, JP}) || (v.st == MW && v.mr)) m_ins++;
        end
        @(posedge clk); #1;
    endtask

    task automatic step(input string tag, input logic r, input logic [5:0] op, input logic z,
                        input logic mr, input logic [3:0] st, input logic [16:0] ctl,
                        input logic ill, input logic bus);
        vec_t v;
        v = '{r, op, z, mr, st, ctl, ill, bus};
        apply(tag, v);
    endtask

    task automatic add(input logic [5:0] op, input logic z, input logic mr,
                       input logic [3:0] st, input logic [16:0] ctl, input logic ill);
        tv.push_back('{1'b0, op, z, mr, st, ctl, ill, 1'b0});
    endtask

    task automatic do_reset();
        step("reset", 1'b1, 6'd0, 1'b0, 1'b0, FE, K_Z, 1'b0, 1'b0);
    endtask

    initial begin
        int         cls, df, dm;
        logic [5:0] op;

        K_Z  = '0;
        K_FS = cw(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b011);
        K_FR = cw(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b011);
        K_DE = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b011);
        K_ER = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000);
        K_EA = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b011);
        K_ES = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010);
        K_MR = cw(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);
        K_MW = cw(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000);
        K_WR = cw(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000);
        K_WI = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000);
        K_WL = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000);
        K_BR = cw(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001);
        K_JP = cw(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);

        // Directed table: R, LW (3 stalls), BEQ z=1/z=0, J, ADDI, SLTI, SW (2 stalls), illegal.
        tv.push_back('{1'b1, 6'd0, 1'b0, 1'b0, FE, K_Z, 1'b0, 1'b0});
        add(6'd0, 0, 1, FE, K_FR, 0); add(6'd0, 0, 1, DE, K_DE, 0);
        add(6'd0, 0, 1, ER, K_ER, 0); add(6'd0, 0, 1, WR, K_WR, 0);
        add(6'd3, 0, 1, FE, K_FR, 0); add(6'd3, 0, 0, DE, K_DE, 0); add(6'd3, 0, 0, MA, K_EA, 0);
        for (int i = 0; i < 3; i++) add(6'd3, 0, 0, MR, K_MR, 0);
        add(6'd3, 0, 1, MR, K_MR, 0); add(6'd3, 0, 0, WL, K_WL, 0);
        add(6'd5, 1, 1, FE, K_FR, 0); add(6'd5, 1, 0, DE, K_DE, 0); add(6'd5, 1, 0, BR, K_BR, 0);
        add(6'd5, 0, 1, FE, K_FR, 0); add(6'd5, 0, 0, DE, K_DE, 0); add(6'd5, 0, 0, BR, K_BR, 0);
        add(6'd6, 0, 1, FE, K_FR, 0); add(6'd6, 0, 0, DE, K_DE, 0); add(6'd6, 0, 0, JP, K_JP, 0);
        add(6'd1, 0, 1, FE, K_FR, 0); add(6'd1, 0, 0, DE, K_DE, 0);
        add(6'd1, 0, 0, EI, K_EA, 0); add(6'd1, 0, 0, WI, K_WI, 0);
        add(6'd2, 0, 1, FE, K_FR, 0); add(6'd2, 0, 0, DE, K_DE, 0);
        add(6'd2, 0, 0, EI, K_ES, 0); add(6'd2, 0, 0, WI, K_WI, 0);
        add(6'd4, 0, 1, FE, K_FR, 0); add(6'd4, 0, 0, DE, K_DE, 0); add(6'd4, 0, 0, MA, K_EA, 0);
        add(6'd4, 0, 0, MW, K_MW, 0); add(6'd4, 0, 0, MW, K_MW, 0); add(6'd4, 0, 1, MW, K_MW, 0);
        add(6'h3f, 0, 0, FE, K_FS, 0); add(6'h3f, 0, 0, FE, K_FS, 0);
        add(6'h3f, 0, 1, FE, K_FR, 0); add(6'h3f, 0, 0, DE, K_DE, 0);
        for (int i = 0; i < 10; i++) add(6'h3f, 0, 1'(i & 1), HL, K_Z, 1);

        @(posedge clk); #1;
        foreach (tv[i]) apply($sformatf("table[%0d]", i), tv[i]);

        // Watchdog expiry in FETCH: four stalled cycles, then HALT with bus_err and mem_read low.
        do_reset();
        for (int i = 0; i < WMAX; i++) step("fetch_stall", 0, 6'd0, 0, 0, FE, K_FS, 0, 0);
        step("fetch_timeout", 0, 6'd0, 0, 0, HL, K_Z, 0, 1);
        step("halt_sticky", 0, 6'd0, 0, 1, HL, K_Z, 0, 1);

        // mem_ready on the cycle the count would expire still completes; counter re-clears.
        do_reset();
        for (int i = 0; i < WMAX - 1; i++) step("fetch_wait", 0, 6'd6, 0, 0, FE, K_FS, 0, 0);
        step("ready_wins", 0, 6'd6, 0, 1, FE, K_FR, 0, 0);
        step("ready_dec", 0, 6'd6, 0, 0, DE, K_DE, 0, 0);
        step("ready_jump", 0, 6'd6, 0, 0, JP, K_JP, 0, 0);
        for (int i = 0; i < WMAX - 1; i++) step("refetch_wait", 0, 6'd0, 0, 0, FE, K_FS, 0, 0);
        step("refetch_ready", 0, 6'd0, 0, 1, FE, K_FR, 0, 0);

        // Watchdog expiry in MEM_RD.
        do_reset();
        step("lw_f", 0, 6'd3, 0, 1, FE, K_FR, 0, 0);
        step("lw_d", 0, 6'd3, 0, 0, DE, K_DE, 0, 0);
        step("lw_a", 0, 6'd3, 0, 0, MA, K_EA, 0, 0);
        for (int i = 0; i < WMAX; i++) step("rd_stall", 0, 6'd3, 0, 0, MR, K_MR, 0, 0);
        step("rd_timeout", 0, 6'd3, 0, 0, HL, K_Z, 0, 1);

        // Asynchronous reset in the middle of a store.
        do_reset();
        step("sw_f", 0, 6'd4, 0, 1, FE, K_FR, 0, 0);
        step("sw_d", 0, 6'd4, 0, 0, DE, K_DE, 0, 0);
        step("sw_a", 0, 6'd4, 0, 0, MA, K_EA, 0, 0);
        step("sw_w", 0, 6'd4, 0, 0, MW, K_MW, 0, 0);
        #1;
        n_vec++;
        if (state_o !== MW || mem_write !== 1'b1) begin
            n_bad++;
            $display("FAIL sw_hold: got st=%0d mem_write=%b, want st=%0d mem_write=1", state_o, mem_write, MW);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (state_o !== FE || act_ctl !== K_Z || mem_write !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst: got st=%0d ctl=%h mem_write=%b, want st=0 ctl=0 mem_write=0", state_o, act_ctl, mem_write);
        end
        @(posedge clk); #1;
        m_cyc = '0; m_ins = '0;
        step("post_rst", 0, 6'd4, 0, 0, FE, K_FS, 0, 0);
        step("post_rst_rdy", 0, 6'd4, 0, 1, FE, K_FR, 0, 0);

        // Random instruction stream checked against a per-instruction recipe.
        do_reset();
        for (int k = 0; k < 200; k++) begin
            cls = int'($urandom_range(0, 9));
            op  = (cls < 7) ? 6'(cls) : 6'($urandom_range(7, 63));
            df  = int'($urandom_range(0, WMAX - 1));
            dm  = int'($urandom_range(0, WMAX - 1));
            for (int i = 0; i < df; i++) step("r_fstall", 0, op, rb(), 0, FE, K_FS, 0, 0);
            step("r_fetch", 0, op, rb(), 1, FE, K_FR, 0, 0);
            step("r_dec", 0, op, rb(), rb(), DE, K_DE, 0, 0);
            case (op)
                6'd0: begin
                    step("r_exr", 0, op, rb(), rb(), ER, K_ER, 0, 0);
                    step("r_wbr", 0, op, rb(), rb(), WR, K_WR, 0, 0);
                end
                6'd1, 6'd2: begin
                    step("r_exi", 0, op, rb(), rb(), EI, (op == 6'd2) ? K_ES : K_EA, 0, 0);
                    step("r_wbi", 0, op, rb(), rb(), WI, K_WI, 0, 0);
                end
                6'd3: begin
                    step("r_lwa", 0, op, rb(), rb(), MA, K_EA, 0, 0);
                    for (int i = 0; i < dm; i++) step("r_rds", 0, op, rb(), 0, MR, K_MR, 0, 0);
                    step("r_rd", 0, op, rb(), 1, MR, K_MR, 0, 0);
                    step("r_wbl", 0, op, rb(), rb(), WL, K_WL, 0, 0);
                end
                6'd4: begin
                    step("r_swa", 0, op, rb(), rb(), MA, K_EA, 0, 0);
                    for (int i = 0; i < dm; i++) step("r_wrs", 0, op, rb(), 0, MW, K_MW, 0, 0);
                    step("r_wr", 0, op, rb(), 1, MW, K_MW, 0, 0);
                end
                6'd5: step("r_beq", 0, op, rb(), rb(), BR, K_BR, 0, 0);
                6'd6: step("r_j", 0, op, rb(), rb(), JP, K_JP, 0, 0);
                default: begin
                    for (int i = 0; i < 3; i++) step("r_halt", 0, op, rb(), rb(), HL, K_Z, 1, 0);
                    do_reset();
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
